lcd_frame_writer: RTL and testbench

//  Downstream of the PPU: takes its 2-bit shade pixel stream plus hblank/vblank markers.

---
 rtl/lcd_frame_writer_if.sv | 32 +++
 rtl/lcd_frame_writer.sv | 178 +++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_writer_if.sv
// Pixel-stream and framebuffer-write bundle for lcd_frame_writer.
// The slave side is the frame writer; the master side drives the PPU stream
// and observes the framebuffer writes and status.
interface lcd_frame_writer_if #(
  parameter int ADDR_W = 15
);
  logic              lcd_on_in;
  logic [1:0]        pixel_in;
  logic              pixel_valid_in;
  logic              hblank_in;
  logic              vblank_in;
  logic              clear_err_in;
  logic              fb_we_out;
  logic [ADDR_W-1:0] fb_addr_out;
  logic [1:0]        fb_data_out;
  logic              fb_wbank_out;
  logic              fb_rbank_out;
  logic              frame_done_out;
  logic [2:0]        err_out;

  modport master (
    output lcd_on_in, pixel_in, pixel_valid_in, hblank_in, vblank_in, clear_err_in,
    input  fb_we_out, fb_addr_out, fb_data_out, fb_wbank_out, fb_rbank_out,
           frame_done_out, err_out
  );

  modport slave (
    input  lcd_on_in, pixel_in, pixel_valid_in, hblank_in, vblank_in, clear_err_in,
    output fb_we_out, fb_addr_out, fb_data_out, fb_wbank_out, fb_rbank_out,
           frame_done_out, err_out
  );
endinterface

// File: rtl/lcd_frame_writer.sv
// LCD frame writer: turns the PPU shade stream into linear framebuffer writes
// (addr = y*H_PIXELS + x), ping-pongs two banks so the display reads a complete
// frame, and keeps sticky {frame_short, line_long, line_short} error flags.
// H_PIXELS*V_LINES must fit in 2**ADDR_W.
module lcd_frame_writer #(
  parameter int H_PIXELS      = 160,
  parameter int V_LINES       = 144,
  parameter int ADDR_W        = 15,
  parameter int DOUBLE_BUFFER = 1
) (
  input logic               clk_in,
  input logic               rst_in,
  lcd_frame_writer_if.slave bus
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     H_MAX  = XW'(H_PIXELS);
  localparam logic [YW-1:0]     V_MAX  = YW'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);
  localparam logic              RBANK_RST = (DOUBLE_BUFFER != 0);

  typedef enum logic [2:0] {IDLE, SYNC, LINE, HWAIT, VWAIT} state_t;

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic              hb_reg, vb_reg;
  logic              fb_we_reg, fb_we_next;
  logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
  logic [1:0]        fb_data_reg, fb_data_next;
  logic              wbank_reg, wbank_next;
  logic              rbank_reg, rbank_next;
  logic              frame_done_reg, frame_done_next;
  logic [2:0]        err_set;
  logic              err_reg [3];

  logic hb_rise, hb_fall, vb_rise, vb_fall, accept;

  assign hb_rise = bus.hblank_in & ~hb_reg;
  assign hb_fall = ~bus.hblank_in & hb_reg;
  assign vb_rise = bus.vblank_in & ~vb_reg;
  assign vb_fall = ~bus.vblank_in & vb_reg;
  assign accept  = bus.pixel_valid_in & ~bus.hblank_in & ~bus.vblank_in;

  // Edge-detect copies of the blanking levels.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hb_reg <= 1'b0;
      vb_reg <= 1'b0;
    end else begin
      hb_reg <= bus.hblank_in;
      vb_reg <= bus.vblank_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next state, position counters, write request, bank swap and error sets.
  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    row_base_next   = row_base_reg;
    fb_we_next      = 1'b0;
    fb_addr_next    = fb_addr_reg;
    fb_data_next    = fb_data_reg;
    wbank_next      = wbank_reg;
    rbank_next      = rbank_reg;
    frame_done_next = 1'b0;
    err_set         = 3'b000;

    if (!bus.lcd_on_in) begin
      // Capture aborted: counters and banks frozen until re-sync.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = SYNC;
        SYNC, VWAIT: begin
          // Only a vblank fall gives a known frame start; earlier pixels are discarded.
          if (vb_fall) begin
            state_next    = LINE;
            x_next        = '0;
            y_next        = '0;
            row_base_next = '0;
          end
        end
        LINE: begin
          if (accept) begin
            if (x_reg < H_MAX) begin
              if (y_reg < V_MAX) begin
                fb_we_next   = 1'b1;
                fb_addr_next = row_base_reg + ADDR_W'(x_reg);
                fb_data_next = bus.pixel_in;
              end
              x_next = x_reg + XW'(1);
            end else if (y_reg < V_MAX) begin
              err_set[1] = 1'b1;
            end
          end
          if (hb_rise) begin
            // Line close; y saturates so extra lines never wrap onto row 0.
            if (x_reg != '0 && x_reg < H_MAX) err_set[0] = 1'b1;
            if (y_reg < V_MAX) begin
              y_next        = y_reg + YW'(1);
              row_base_next = row_base_reg + H_STEP;
            end
            x_next     = '0;
            state_next = HWAIT;
          end
        end
        HWAIT: if (hb_fall) state_next = LINE;
        default: state_next = IDLE;
      endcase

      if (state_reg != IDLE && vb_rise) begin
        // Frame close sees y after any line close of this same cycle.
        if (state_reg == LINE || state_reg == HWAIT) begin
          frame_done_next = 1'b1;
          if (DOUBLE_BUFFER != 0) begin
            wbank_next = ~wbank_reg;
            rbank_next = wbank_reg;
          end
          if (y_next != V_MAX) err_set[2] = 1'b1;
        end
        state_next = VWAIT;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_reg          <= '0;
      y_reg          <= '0;
      row_base_reg   <= '0;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= 2'b00;
      wbank_reg      <= 1'b0;
      rbank_reg      <= RBANK_RST;
      frame_done_reg <= 1'b0;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      row_base_reg   <= row_base_next;
      fb_we_reg      <= fb_we_next;
      fb_addr_reg    <= fb_addr_next;
      fb_data_reg    <= fb_data_next;
      wbank_reg      <= wbank_next;
      rbank_reg      <= rbank_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Sticky error bits; a new set beats a simultaneous clear.
  for (genvar gi = 0; gi < 3; gi++) begin : g_err
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)               err_reg[gi] <= 1'b0;
      else if (err_set[gi])      err_reg[gi] <= 1'b1;
      else if (bus.clear_err_in) err_reg[gi] <= 1'b0;
    end
  end

  assign bus.fb_we_out      = fb_we_reg;
  assign bus.fb_addr_out    = fb_addr_reg;
  assign bus.fb_data_out    = fb_data_reg;
  assign bus.fb_wbank_out   = wbank_reg;
  assign bus.fb_rbank_out   = rbank_reg;
  assign bus.frame_done_out = frame_done_reg;
  assign bus.err_out        = {err_reg[2], err_reg[1], err_reg[0]};

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: full frame, short/long lines, short
// frame, LCD disable/re-enable and asynchronous reset mid-line.
module tb_lcd_frame_writer;
  localparam int H  = 160;
  localparam int V  = 144;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_frame_writer_if #(.ADDR_W(AW)) bus ();

  lcd_frame_writer #(
    .H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .DOUBLE_BUFFER(1)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Write/frame_done monitor, sampled mid-cycle.
  int          wr_count  = 0;
  int          fd_count  = 0;
  int          data_bad  = 0;
  logic [AW-1:0] addr_log [0:65535];
  int          mon_a;
  logic [1:0]  mon_exp;

  always @(negedge clk) begin
    if (bus.fb_we_out === 1'b1) begin
      mon_a   = int'(bus.fb_addr_out);
      mon_exp = 2'(((mon_a % H) + (mon_a / H)) & 3);
      if (bus.fb_data_out !== mon_exp) data_bad++;
      addr_log[wr_count & 16'hffff] = bus.fb_addr_out;
      wr_count++;
    end
    if (bus.frame_done_out === 1'b1) fd_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixels(input int n, input int y);
    for (int i = 0; i < n; i++) begin
      bus.pixel_in       = 2'((i + y) & 3);
      bus.pixel_valid_in = 1'b1;
      tick(1);
    end
    bus.pixel_valid_in = 1'b0;
  endtask

  task automatic send_line(input int n, input int y);
    send_pixels(n, y);
    bus.hblank_in = 1'b1;
    tick(2);
    bus.hblank_in = 1'b0;
    tick(1);
  endtask

  task automatic vblank_pulse();
    bus.vblank_in = 1'b1;
    tick(3);
    bus.vblank_in = 1'b0;
    tick(1);
  endtask

  task automatic clear_err();
    bus.clear_err_in = 1'b1;
    tick(1);
    bus.clear_err_in = 1'b0;
    tick(1);
  endtask

  int w0;

  initial begin
    rst_n              = 1'b0;
    bus.lcd_on_in      = 1'b0;
    bus.pixel_in       = 2'b00;
    bus.pixel_valid_in = 1'b0;
    bus.hblank_in      = 1'b0;
    bus.vblank_in      = 1'b0;
    bus.clear_err_in   = 1'b0;
    tick(2);

    // Reset state
    check("rst_we",    bus.fb_we_out, 0);
    check("rst_addr",  bus.fb_addr_out, 0);
    check("rst_data",  bus.fb_data_out, 0);
    check("rst_wbank", bus.fb_wbank_out, 0);
    check("rst_rbank", bus.fb_rbank_out, 1);
    check("rst_done",  bus.frame_done_out, 0);
    check("rst_err",   bus.err_out, 0);
    $display("reset state checked");

    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Partial frame before the first vblank fall is discarded
    bus.lcd_on_in = 1'b1;
    tick(2);
    send_line(20, 0);
    check("sync_nowrite", wr_count, 0);
    vblank_pulse();
    check("sync_nodone", fd_count, 0);
    $display("sync discard: writes=%0d frame_done=%0d", wr_count, fd_count);

    // 1: full frame
    for (int y = 0; y < V; y++) send_line(H, y);
    vblank_pulse();
    check("f1_writes", wr_count, 23040);
    check("f1_last",   addr_log[23039], 23039);
    check("f1_done",   fd_count, 1);
    check("f1_wbank",  bus.fb_wbank_out, 1);
    check("f1_rbank",  bus.fb_rbank_out, 0);
    check("f1_err",    bus.err_out, 0);
    check("f1_data",   data_bad, 0);
    $display("frame1: writes=%0d done=%0d err=%b", wr_count, fd_count, bus.err_out);

    // 2: short line 5, line 6 starts at 960, then early vblank
    for (int y = 0; y < 5; y++) send_line(H, y);
    send_line(150, 5);
    check("f2_err_short", bus.err_out, 3'b001);
    w0 = wr_count;
    send_line(H, 6);
    check("f2_l6_addr",  addr_log[w0 & 16'hffff], 960);
    check("f2_l6_count", wr_count - w0, 160);
    vblank_pulse();
    check("f2_err", bus.err_out, 3'b101);
    check("f2_done", fd_count, 2);
    check("f2_wbank", bus.fb_wbank_out, 0);
    check("f2_rbank", bus.fb_rbank_out, 1);
    clear_err();
    check("f2_clear", bus.err_out, 0);
    $display("frame2: line6 first addr=%0d done=%0d", addr_log[w0 & 16'hffff], fd_count);

    // 3: long line 0 writes only 0..159
    w0 = wr_count;
    send_line(165, 0);
    check("f3_count", wr_count - w0, 160);
    check("f3_last",  addr_log[(w0 + 159) & 16'hffff], 159);
    check("f3_err",   bus.err_out, 3'b010);
    vblank_pulse();
    check("f3_done",  fd_count, 3);
    clear_err();
    $display("frame3: long line writes=%0d", wr_count - w0);

    // 4: vblank after 100 lines
    w0 = wr_count;
    for (int y = 0; y < 100; y++) send_line(H, y);
    vblank_pulse();
    check("f4_count", wr_count - w0, 16000);
    check("f4_done",  fd_count, 4);
    check("f4_wbank", bus.fb_wbank_out, 0);
    check("f4_rbank", bus.fb_rbank_out, 1);
    check("f4_err",   bus.err_out, 3'b100);
    clear_err();
    $display("frame4: short frame err flagged, done=%0d", fd_count);

    // 5: LCD off at line 50, pixels and vblank ignored
    w0 = wr_count;
    for (int y = 0; y < 50; y++) send_line(H, y);
    send_pixels(30, 50);
    bus.lcd_on_in      = 1'b0;
    bus.pixel_valid_in = 1'b1;
    tick(3);
    bus.pixel_valid_in = 1'b0;
    check("f5_count", wr_count - w0, 50 * H + 30);
    vblank_pulse();
    check("f5_nodone", fd_count, 4);
    check("f5_wbank",  bus.fb_wbank_out, 0);
    check("f5_rbank",  bus.fb_rbank_out, 1);
    w0 = wr_count;
    bus.lcd_on_in = 1'b1;
    tick(1);
    send_line(20, 0);
    check("f5_resync_nowrite", wr_count - w0, 0);
    vblank_pulse();
    check("f5_resync_nodone", fd_count, 4);
    send_line(10, 0);
    check("f5_restart_addr",  addr_log[w0 & 16'hffff], 0);
    check("f5_restart_count", wr_count - w0, 10);
    vblank_pulse();
    check("f5_done",  fd_count, 5);
    check("f5_wbank2", bus.fb_wbank_out, 1);
    check("f5_rbank2", bus.fb_rbank_out, 0);
    $display("frame5: lcd off/on, restart writes=%0d", wr_count - w0);

    // 6: async reset mid-line while writing
    send_pixels(5, 0);
    bus.pixel_valid_in = 1'b1;
    tick(1);
    check("f6_we_before", bus.fb_we_out, 1);
    #2;
    rst_n = 1'b0;
    bus.pixel_valid_in = 1'b0;
    #1;
    check("f6_we_async", bus.fb_we_out, 0);
    check("f6_rbank",    bus.fb_rbank_out, 1);
    check("f6_wbank",    bus.fb_wbank_out, 0);
    check("f6_err",      bus.err_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_count;
    tick(1);
    send_line(20, 0);
    check("f6_idle_nowrite", wr_count - w0, 0);
    check("f6_data", data_bad, 0);
    $display("reset mid-line: writes after release=%0d", wr_count - w0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
